// File: rtl/fp_accumulator.sv
// ----------------------------------------------------------------------------
// fp_accumulator
//
// Multi-cycle IEEE-754 single-precision accumulator. Sits behind the FP32
// multiplier and sums a programmed number of products into a running total.
// Follows the multiplier's arithmetic conventions: truncation only, and
// exponent-field-zero operands are treated as zero.
//
// Each term takes four cycles:
//   WAIT_IN -> ALIGN -> ADD -> NORM -> (WAIT_IN | DONE)
//
// Build option:
//   FP_ACC_SAT_EN  defined   : overflow saturates to +/- max finite (0x7F7FFFFF)
//                  undefined : overflow produces +/- infinity       (0x7F800000)
//   In both builds the sticky ovf flag is set on overflow.
//
// Ports:
//   s00_axi_aclk     in   clock, rising edge
//   s00_axi_aresetn  in   asynchronous active-low reset
//   start            in   begin a new accumulation (sampled in IDLE only)
//   num_terms        in   number of terms to sum, latched on start
//   in_valid         in   product available on in_data
//   in_ready         out  a term is accepted this cycle (decoded from state)
//   in_data          in   FP32 product
//   out_valid        out  out_data holds the final sum (registered)
//   out_ready        in   consumer takes the result
//   out_data         out  FP32 sum (registered)
//   busy             out  high in every state except IDLE (decoded from state)
//   ovf              out  sticky exponent overflow for the current accumulation
// ----------------------------------------------------------------------------
module fp_accumulator #(
    parameter int CNT_W = 8
) (
    input  logic             s00_axi_aclk,
    input  logic             s00_axi_aresetn,
    input  logic             start,
    input  logic [CNT_W-1:0] num_terms,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             busy,
    output logic             ovf
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_IN = 3'd1,
        ALIGN   = 3'd2,
        ADD     = 3'd3,
        NORM    = 3'd4,
        DONE    = 3'd5
    } state_e;

    // Magnitude (exponent + mantissa) substituted on exponent overflow.
`ifdef FP_ACC_SAT_EN
    localparam logic [30:0] OVF_MAG = {8'hFE, 23'h7FFFFF};
`else
    localparam logic [30:0] OVF_MAG = {8'hFF, 23'h000000};
`endif

    // ------------------------------------------------------------------
    // State and pipeline registers
    // ------------------------------------------------------------------
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;        // terms still to be accepted
    logic [31:0]      acc_q;        // running total
    logic [31:0]      term_q;       // captured incoming term

    // ALIGN -> ADD
    logic             big_sign_q;
    logic [7:0]       big_exp_q;
    logic [23:0]      big_sig_q;
    logic [23:0]      small_sig_q;  // already shifted to the larger exponent
    logic             sub_q;        // operand signs differ

    // ADD -> NORM
    logic [24:0]      sum_q;

    // Registered outputs
    logic             out_valid_q;
    logic [31:0]      out_data_q;
    logic             ovf_q;

    // ------------------------------------------------------------------
    // ALIGN stage: order operands by magnitude and shift the smaller one
    // ------------------------------------------------------------------
    logic        a_zero, b_zero;
    logic [30:0] a_mag, b_mag;
    logic [23:0] a_sig, b_sig;
    logic        a_big;
    logic        big_sign_d;
    logic [7:0]  big_exp_d;
    logic [7:0]  small_exp;
    logic [23:0] big_sig_d;
    logic [23:0] small_sig_raw;
    logic [7:0]  exp_diff;
    logic [23:0] small_sig_d;
    logic        sub_d;

    // NOTE: every combinational output gets a default at the top of the
    // block so that no path leaves it unassigned and infers a latch.
    always_comb begin
        a_zero = (acc_q[30:23] == 8'd0);
        b_zero = (term_q[30:23] == 8'd0);

        // A zero-exponent operand contributes nothing, whatever its mantissa.
        a_mag = a_zero ? 31'd0 : acc_q[30:0];
        b_mag = b_zero ? 31'd0 : term_q[30:0];
        a_sig = a_zero ? 24'd0 : {1'b1, acc_q[22:0]};
        b_sig = b_zero ? 24'd0 : {1'b1, term_q[22:0]};

        // Exponent and mantissa are contiguous, so one compare orders
        // by exponent first and mantissa second.
        a_big = (a_mag >= b_mag);

        big_sign_d    = a_big ? acc_q[31]    : term_q[31];
        big_exp_d     = a_big ? acc_q[30:23] : term_q[30:23];
        small_exp     = a_big ? term_q[30:23] : acc_q[30:23];
        big_sig_d     = a_big ? a_sig : b_sig;
        small_sig_raw = a_big ? b_sig : a_sig;

        // big_exp_d >= small_exp by construction, so no wrap.
        exp_diff    = big_exp_d - small_exp;
        small_sig_d = (exp_diff >= 8'd24) ? 24'd0 : (small_sig_raw >> exp_diff);

        sub_d = acc_q[31] ^ term_q[31];
    end

    // ------------------------------------------------------------------
    // ADD stage: 25-bit magnitude add or larger-minus-smaller subtract
    // ------------------------------------------------------------------
    logic [24:0] sum_d;

    always_comb begin
        if (sub_q) begin
            sum_d = {1'b0, big_sig_q} - {1'b0, small_sig_q};
        end else begin
            sum_d = {1'b0, big_sig_q} + {1'b0, small_sig_q};
        end
    end

    // ------------------------------------------------------------------
    // NORM stage: single-cycle priority-encoded normalisation
    // ------------------------------------------------------------------
    logic [4:0]        lzc;
    logic              lz_found;
    logic signed [9:0] exp_ext;
    logic signed [9:0] exp_norm;
    logic [22:0]       mant_norm;
    logic [31:0]       norm_res_d;
    logic              norm_ovf_d;

    always_comb begin
        // Leading-zero count over the 24-bit field below the carry bit.
        lzc      = 5'd0;
        lz_found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!lz_found && sum_q[i]) begin
                lzc      = 5'(23 - i);
                lz_found = 1'b1;
            end
        end

        exp_ext = $signed({2'b00, big_exp_q});

        if (sum_q[24]) begin
            exp_norm  = exp_ext + 10'sd1;
            mant_norm = sum_q[23:1];
        end else begin
            exp_norm  = exp_ext - $signed({5'd0, lzc});
            // The leading one lands in the hidden-bit position and is
            // dropped; only the bits below it form the mantissa.
            mant_norm = sum_q[22:0] << lzc;
        end

        norm_ovf_d = 1'b0;
        norm_res_d = {big_sign_q, exp_norm[7:0], mant_norm};

        if (sum_q == 25'd0) begin
            norm_res_d = 32'd0;              // exact zero is always +0
        end else if (exp_norm <= 10'sd0) begin
            norm_res_d = 32'd0;              // underflow flushes to +0
        end else if (exp_norm >= 10'sd255) begin
            norm_ovf_d = 1'b1;
            norm_res_d = {big_sign_q, OVF_MAG};
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the values present before the clock edge.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= 32'd0;
            term_q      <= 32'd0;
            big_sign_q  <= 1'b0;
            big_exp_q   <= 8'd0;
            big_sig_q   <= 24'd0;
            small_sig_q <= 24'd0;
            sub_q       <= 1'b0;
            sum_q       <= 25'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q <= num_terms;
                        acc_q <= 32'd0;
                        ovf_q <= 1'b0;
                        if (num_terms == '0) begin
                            // Empty sum: report +0 straight away.
                            out_valid_q <= 1'b1;
                            out_data_q  <= 32'd0;
                            state_q     <= DONE;
                        end else begin
                            state_q <= WAIT_IN;
                        end
                    end
                end

                WAIT_IN: begin
                    if (in_valid) begin
                        term_q  <= in_data;
                        cnt_q   <= cnt_q - CNT_W'(1);
                        state_q <= ALIGN;
                    end
                end

                ALIGN: begin
                    big_sign_q  <= big_sign_d;
                    big_exp_q   <= big_exp_d;
                    big_sig_q   <= big_sig_d;
                    small_sig_q <= small_sig_d;
                    sub_q       <= sub_d;
                    state_q     <= ADD;
                end

                ADD: begin
                    sum_q   <= sum_d;
                    state_q <= NORM;
                end

                NORM: begin
                    // An overflowed total keeps accumulating from the
                    // substituted value; ovf stays set until the next start.
                    acc_q <= norm_res_d;
                    if (norm_ovf_d) begin
                        ovf_q <= 1'b1;
                    end
                    if (cnt_q == '0) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= norm_res_d;
                        state_q     <= DONE;
                    end else begin
                        state_q <= WAIT_IN;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = (state_q == WAIT_IN);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fp_accumulator.sv
// ----------------------------------------------------------------------------
// tb_fp_accumulator
//
// Directed, table-driven bench for fp_accumulator. Each table record holds the
// terms to feed and the hand-computed sum and overflow flag. Hand-written
// sequences cover gapped input, result back-pressure and reset mid-term.
// Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_fp_accumulator;

`ifdef FP_ACC_SAT_EN
    localparam logic [31:0] OVF_POS = 32'h7F7FFFFF;
    localparam logic [31:0] OVF_NEG = 32'hFF7FFFFF;
`else
    localparam logic [31:0] OVF_POS = 32'h7F800000;
    localparam logic [31:0] OVF_NEG = 32'hFF800000;
`endif

    localparam int BUDGET = 200;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  num_terms;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
    logic        ovf;

    int n_checks = 0;
    int n_err    = 0;

    fp_accumulator #(.CNT_W(8)) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .start           (start),
        .num_terms       (num_terms),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .busy            (busy),
        .ovf             (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [7:0]       n;
        logic [2:0][31:0] t;
        logic [31:0]      exp_data;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input string name, input logic [7:0] n,
                                input logic [31:0] t0, input logic [31:0] t1,
                                input logic [31:0] t2, input logic [31:0] exp_data,
                                input logic exp_ovf);
        vec_t v;
        v.name     = name;
        v.n        = n;
        v.t[0]     = t0;
        v.t[1]     = t1;
        v.t[2]     = t2;
        v.exp_data = exp_data;
        v.exp_ovf  = exp_ovf;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Start an accumulation, stream the terms back-to-back, then check the
    // result, flag, latency and return to IDLE.
    task automatic run_vec(input vec_t v);
        int   k;
        int   idx;
        logic accepted;
        logic rdy_seen;
        @(negedge clk);
        start     = 1'b1;
        num_terms = v.n;
        @(negedge clk);
        start    = 1'b0;
        k        = 1;
        idx      = 0;
        rdy_seen = 1'b0;
        in_valid = (v.n != 8'd0);
        in_data  = v.t[0];
        while (!out_valid && k <= BUDGET) begin
            rdy_seen = rdy_seen | in_ready;
            accepted = in_valid && in_ready;
            @(negedge clk);
            k++;
            if (accepted) idx++;
            in_valid = (idx < int'(v.n));
            in_data  = (idx < 3) ? v.t[idx] : 32'd0;
        end
        in_valid = 1'b0;
        check({v.name, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({v.name, "_data"}, out_data, v.exp_data);
        check({v.name, "_ovf"}, {31'd0, ovf}, {31'd0, v.exp_ovf});
        check({v.name, "_latency"}, 32'(k), 32'(1 + 4 * int'(v.n)));
        if (v.n == 8'd0) check({v.name, "_no_in_ready"}, {31'd0, rdy_seen}, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({v.name, "_idle_busy"}, {31'd0, busy}, 32'd0);
        check({v.name, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic wait_in_ready(input string name);
        int w;
        w = 0;
        while (!in_ready && w < BUDGET) begin
            @(negedge clk);
            w++;
        end
        check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({name, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({name, "_out_data"}, out_data, 32'd0);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_ovf"}, {31'd0, ovf}, 32'd0);
    endtask

    initial begin
        vecs[0]  = mk("add_pos",   8'd2, 32'h3FC00000, 32'h40200000, 32'h0, 32'h40800000, 1'b0);
        vecs[1]  = mk("cancel",    8'd2, 32'h40400000, 32'hC0400000, 32'h0, 32'h00000000, 1'b0);
        vecs[2]  = mk("zero_n",    8'd0, 32'h3F800000, 32'h0,        32'h0, 32'h00000000, 1'b0);
        vecs[3]  = mk("ovf_pos",   8'd2, 32'h7F000000, 32'h7F000000, 32'h0, OVF_POS,      1'b1);
        vecs[4]  = mk("one_term",  8'd1, 32'h3F800000, 32'h0,        32'h0, 32'h3F800000, 1'b0);
        vecs[5]  = mk("sub_norm",  8'd2, 32'h3F800000, 32'hBE800000, 32'h0, 32'h3F400000, 1'b0);
        vecs[6]  = mk("diff24",    8'd2, 32'h3F800000, 32'h33800000, 32'h0, 32'h3F800000, 1'b0);
        vecs[7]  = mk("diff23",    8'd2, 32'h3F800000, 32'h34000000, 32'h0, 32'h3F800001, 1'b0);
        vecs[8]  = mk("neg_add",   8'd2, 32'hBFC00000, 32'hC0200000, 32'h0, 32'hC0800000, 1'b0);
        vecs[9]  = mk("denorm",    8'd2, 32'h00400000, 32'h3F800000, 32'h0, 32'h3F800000, 1'b0);
        vecs[10] = mk("underflow", 8'd2, 32'h00C00000, 32'h80800000, 32'h0, 32'h00000000, 1'b0);
        vecs[11] = mk("three",     8'd3, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40400000, 1'b0);
        vecs[12] = mk("sign_flip", 8'd2, 32'h3F800000, 32'hC0400000, 32'h0, 32'hC0000000, 1'b0);
        vecs[13] = mk("ovf_neg",   8'd2, 32'hFF000000, 32'hFF000000, 32'h0, OVF_NEG,      1'b1);

        rst_n     = 1'b0;
        start     = 1'b0;
        num_terms = 8'd0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i]);
        end

        // Gapped input: three 1.0 terms, each offered two cycles after
        // in_ready rises, then the result is held back for five cycles.
        begin
            int w;
            @(negedge clk);
            start     = 1'b1;
            num_terms = 8'd3;
            @(negedge clk);
            start = 1'b0;
            for (int t = 0; t < 3; t++) begin
                wait_in_ready("gap_wait");
                repeat (2) @(negedge clk);
                check("gap_ready_held", {31'd0, in_ready}, 32'd1);
                in_valid = 1'b1;
                in_data  = 32'h3F800000;
                @(negedge clk);
                in_valid = 1'b0;
            end
            w = 0;
            while (!out_valid && w < BUDGET) begin
                @(negedge clk);
                w++;
            end
            for (int c = 0; c < 5; c++) begin
                check("gap_hold_valid", {31'd0, out_valid}, 32'd1);
                check("gap_hold_data", out_data, 32'h40400000);
                @(negedge clk);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check("gap_idle_busy", {31'd0, busy}, 32'd0);
            check("gap_idle_valid", {31'd0, out_valid}, 32'd0);
        end

        // Reset while the second term is in ADD, then a clean single term.
        @(negedge clk);
        start     = 1'b1;
        num_terms = 8'd2;
        @(negedge clk);
        start = 1'b0;
        wait_in_ready("rst_t1");
        in_valid = 1'b1;
        in_data  = 32'h3F800000;
        @(negedge clk);
        in_valid = 1'b0;
        wait_in_ready("rst_t2");
        in_valid = 1'b1;
        in_data  = 32'h3F800000;
        @(negedge clk);          // ALIGN
        in_valid = 1'b0;
        @(negedge clk);          // ADD
        check("rst_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        check_all_zero("rst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(mk("after_rst", 8'd1, 32'h3F800000, 32'h0, 32'h0, 32'h3F800000, 1'b0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_accumulator.md
# fp_accumulator

Multi-cycle IEEE-754 single-precision accumulator that sits directly downstream of `floating_point_multiplier` in the `acc` IP. It consumes a stream of products over a valid/ready handshake and sums a programmed number of terms into a running total, which gives the dot-product path its reduction stage. Arithmetic matches the multiplier's conventions:
- no rounding (truncation only);
- no denormals, NaN or infinity inputs.

## Interface
- `CNT_W`, 8, width of the term counter and `num_terms`.
- `s00_axi_aclk` in 1: clock; all state changes on the rising edge.
- `s00_axi_aresetn` in 1: asynchronous active-low reset.
- `start` in 1: begin a new accumulation. Sampled only in IDLE.
- `num_terms` in CNT_W: number of terms to sum. Latched on `start`.
- `in_valid` in 1: product available on `in_data`.
- `in_ready` out 1: accumulator accepts a term this cycle.
- `in_data` in 32: FP32 product.
- `out_valid` out 1: `out_data` holds the final sum.
- `out_ready` in 1: consumer takes the result.
- `out_data` out 32: FP32 sum.
- `busy` out 1: high in every state except IDLE.
- `ovf` out 1: sticky exponent-overflow flag for the current accumulation. Cleared on `start`.

## Operation
- States are IDLE, WAIT_IN, ALIGN, ADD, NORM and DONE.
- **IDLE**
  - On `start`: latch `num_terms` into the remaining counter, clear the accumulator to +0 and clear `ovf`.
  - If `num_terms`==0, go to DONE; otherwise go to WAIT_IN.
  - `start` outside IDLE is ignored.
- **WAIT_IN**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, capture `in_data`, decrement the counter and go to ALIGN.
- **ALIGN**
  - Any operand with exponent field 0 is treated as zero, whatever its mantissa.
  - Form 24-bit significands with the hidden 1.
  - Order the two operands by magnitude (exponent, then mantissa).
  - Shift the smaller significand right by the exponent difference, discarding shifted-out bits.
  - A difference ≥ 24 makes the smaller operand zero.
- **ADD**
  - Signs equal: 25-bit magnitude add.
  - Signs differ: larger minus smaller.
  - The result sign is the sign of the larger operand. An exact zero result is +0.
- **NORM**
  - Carry out: shift right 1, exponent +1.
  - Otherwise: shift left by the leading-zero count, exponent minus that count, in a single cycle (priority encoder).
  - Zero result: +0.
  - Exponent ≤ 0 after normalisation: flush to +0.
  - Exponent ≥ 255: set `ovf` and apply the overflow behaviour in Configuration.
  - Write the result back to the accumulator.
  - Go to DONE if the counter is 0, otherwise go to WAIT_IN.
- **DONE**
  - `out_valid`=1 and `out_data`=accumulator, held stable until `out_ready`.
  - On `out_valid`&&`out_ready`, go to IDLE.
- Overflowed terms keep accumulating from the overflow value. `ovf` stays set until the next `start`.
- Reset (asynchronous, any state) forces:
  - state IDLE;
  - `in_ready`=0, `out_valid`=0, `out_data`=0, `busy`=0, `ovf`=0;
  - counter and accumulator cleared.
- An in-flight term is discarded on reset. No output is produced for an interrupted accumulation.

## Timing
- All outputs are registered except `in_ready` and `busy`, which are decoded from state.
- `start` in cycle T: WAIT_IN in T+1, so `in_ready` is high from T+1.
- A term accepted in cycle A: ALIGN in A+1, ADD in A+2, NORM in A+3.
  - Not the last term: WAIT_IN, and `in_ready` high again, in A+4.
  - Last term: `out_valid` high in A+4.
- Throughput is one term per 4 cycles with no input stalls.
- N terms with no stalls: `out_valid` rises at T+1+4N.
- `num_terms`==0: `out_valid`=1 with `out_data`=0x00000000 at T+1.
- `in_valid` may assert before `in_ready`; the term is held upstream until WAIT_IN.
- `out_ready` may be high before `out_valid`. The result transfers in the first DONE cycle, and `start` is accepted from the next cycle.

## Configuration
- `FP_ACC_SAT_EN` defined: on overflow the result saturates to ±max finite, exponent 254 and mantissa 0x7FFFFF (0x7F7FFFFF / 0xFF7FFFFF).
- `FP_ACC_SAT_EN` undefined: on overflow the result is ±infinity, exponent 255 and mantissa 0 (0x7F800000 / 0xFF800000).
- `ovf` is set in both builds.

## Test plan
- `num_terms`=2 with 0x3FC00000 (1.5) then 0x40200000 (2.5) -> `out_data`=0x40800000 (4.0), `ovf`=0, `out_valid` at T+9.
- `num_terms`=2 with 0x40400000 then 0xC0400000 -> `out_data`=0x00000000.
- `num_terms`=0 and `start` -> `out_valid` at T+1 with 0x00000000; `in_ready` never asserted.
- `num_terms`=2 with 0x7F000000 twice -> `ovf`=1, `out_data`=0x7F7FFFFF with `FP_ACC_SAT_EN`, 0x7F800000 without.
- `num_terms`=3 with 0x3F800000 ×3 and `in_valid` gapped 2 cycles per term, `out_ready` low for 5 cycles -> `out_data`=0x40400000 held stable until `out_ready`, then IDLE.
- `s00_axi_aresetn` low during ADD of the second term -> all outputs 0 immediately. A new `start` with 0x3F800000 ×1 -> 0x3F800000 and no residue.
